// File: rtl/brick_pkg.sv
// rtl/brick_pkg.sv - shared screen constants, field widths and ball FSM states
//
// Purpose: common definitions for the brick breaker datapath blocks.
// Contents:
//   SCREEN_X_MAX, SCREEN_Y_MAX   playfield extents (pixels)
//   SCREEN_PADDLE_Y              paddle row
//   SCREEN_PADDLE_W              paddle width (pixels)
//   X_W, Y_W                     ball coordinate widths
//   ball_state_t                 ball controller FSM states

package brick_pkg;

  localparam int SCREEN_X_MAX    = 159;
  localparam int SCREEN_Y_MAX    = 119;
  localparam int SCREEN_PADDLE_Y = 116;
  localparam int SCREEN_PADDLE_W = 16;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_MOVE  = 3'd3,
    ST_LOST  = 3'd4
  } ball_state_t;

endpackage

// File: rtl/rate_divider.sv
// rtl/rate_divider.sv - free-running step counter with hold and terminal pulse
//
// Purpose: counts clocks while enabled and pulses tick on the last count of
// each TICK_DIV-clock period, wrapping back to zero.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous active-high reset, clears the count
//   hold   in  1  forces the count to zero while high
//   tick   out 1  high during the cycle the count equals TICK_DIV-1

module rate_divider #(
  parameter int TICK_DIV = 833_333
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || hold) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Derived from the count register and hold only; hold comes from the
  // owner's state register, so no input-to-output path is created.
  assign tick = !hold && (count == LAST);

endmodule

// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - ball motion controller: step strobe, direction and loss
//
// Purpose: paces ball steps, bounces the ball off walls, paddle and bricks,
// and reports when the ball falls past the paddle row.
// Ports:
//   clk        in  1  system clock
//   reset      in  1  synchronous active-high reset
//   start      in  1  launch request, honoured only in IDLE
//   x          in  8  current ball column
//   y          in  7  current ball row
//   paddle_x   in  8  paddle left column
//   brick_hit  in  1  one-cycle brick collision pulse
//   enable     out 1  one-cycle move strobe to ball_pos
//   x_du       out 1  1 = x increments, 0 = x decrements
//   y_du       out 1  1 = y increments (down), 0 = y decrements
//   ball_lost  out 1  one-cycle pulse when the ball misses the paddle
//   running    out 1  high in every state except IDLE

module ball_ctrl
  import brick_pkg::*;
#(
  parameter int TICK_DIV = 833_333,
  parameter int X_MAX    = brick_pkg::SCREEN_X_MAX,
  parameter int Y_MAX    = brick_pkg::SCREEN_Y_MAX,
  parameter int PADDLE_Y = brick_pkg::SCREEN_PADDLE_Y,
  parameter int PADDLE_W = brick_pkg::SCREEN_PADDLE_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] paddle_x,
  input  logic           brick_hit,
  output logic           enable,
  output logic           x_du,
  output logic           y_du,
  output logic           ball_lost,
  output logic           running
);

  localparam logic [X_W-1:0] X_MAX_V     = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MAX_V     = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] BOUNCE_ROW  = Y_W'(PADDLE_Y - 1);
  localparam logic [X_W:0]   PADDLE_W_V  = (X_W + 1)'(PADDLE_W);

  ball_state_t state;
  logic        brick_flag;
  logic        step_tick;

  rate_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_rate_divider (
    .clk   (clk),
    .reset (reset),
    .hold  (state != ST_RUN),
    .tick  (step_tick)
  );

  // Collision decode, used only in CHECK.
  logic       x_flip;
  logic       in_paddle;
  logic       flip_y;
  logic       lost_hit;
  logic [X_W:0] x_ext;
  logic [X_W:0] pad_lo;
  logic [X_W:0] pad_hi;

  always_comb begin
    x_ext  = {1'b0, x};
    pad_lo = {1'b0, paddle_x};
    // 9-bit upper bound so a paddle near the right edge cannot wrap to 0.
    pad_hi = pad_lo + PADDLE_W_V;

    x_flip    = (x_du && (x == X_MAX_V)) || (!x_du && (x == '0));
    in_paddle = (x_ext >= pad_lo) && (x_ext < pad_hi);

    // OR of all sources: coincident causes produce a single toggle.
    flip_y    = (!y_du && (y == '0))
             || (y_du && (y == BOUNCE_ROW) && in_paddle)
             || brick_flag;
    lost_hit  = y_du && (y == Y_MAX_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      enable     <= 1'b0;
      x_du       <= 1'b1;
      y_du       <= 1'b1;
      ball_lost  <= 1'b0;
      running    <= 1'b0;
      brick_flag <= 1'b0;
    end else begin
      enable    <= 1'b0;
      ball_lost <= 1'b0;

      case (state)
        ST_IDLE: begin
          brick_flag <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        ST_RUN: begin
          if (brick_hit) begin
            brick_flag <= 1'b1;
          end
          if (step_tick) begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          // A hit landing during CHECK is kept for the next CHECK.
          brick_flag <= brick_hit;
          if (lost_hit) begin
            state     <= ST_LOST;
            ball_lost <= 1'b1;
          end else begin
            if (x_flip) begin
              x_du <= !x_du;
            end
            if (flip_y) begin
              y_du <= !y_du;
            end
            state  <= ST_MOVE;
            enable <= 1'b1;
          end
        end

        ST_MOVE: begin
          if (brick_hit) begin
            brick_flag <= 1'b1;
          end
          state <= ST_RUN;
        end

        ST_LOST: begin
          brick_flag <= 1'b0;
          x_du       <= 1'b1;
          y_du       <= 1'b1;
          running    <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - directed self-checking bench for ball_ctrl

module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x = 8'd80;
  logic [6:0] y = 7'd50;
  logic [7:0] paddle_x = 8'd0;
  logic       brick_hit = 1'b0;
  logic       enable;
  logic       x_du;
  logic       y_du;
  logic       ball_lost;
  logic       running;

  int tests = 0;
  int fails = 0;

  ball_ctrl #(
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .y         (y),
    .paddle_x  (paddle_x),
    .brick_hit (brick_hit),
    .enable    (enable),
    .x_du      (x_du),
    .y_du      (y_du),
    .ball_lost (ball_lost),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until enable is seen, bounded; the number of cycles taken is checked.
  task automatic next_move(input string tag, input int exp_cycles);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!enable && n < 20);
    check(tag, n, exp_cycles);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_enable", enable, 0);
    check("rst_running", running, 0);
    check("rst_x_du", x_du, 1);
    check("rst_y_du", y_du, 1);
    check("rst_lost", ball_lost, 0);
    reset = 1'b0;

    // Launch and first step latency
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_running", running, 1);
    check("start_enable", enable, 0);
    next_move("first_step_latency", 5);
    check("first_x_du", x_du, 1);
    check("first_y_du", y_du, 1);
    tick();
    check("enable_one_cycle", enable, 0);

    // Right wall
    x = 8'd159;
    next_move("rwall_latency", 5);
    check("rwall_x_du", x_du, 0);
    check("rwall_y_du", y_du, 1);

    // Left wall
    x = 8'd0;
    next_move("lwall_period", 6);
    check("lwall_x_du", x_du, 1);

    // Paddle hit near right edge (9-bit bound)
    x = 8'd165; y = 7'd115; paddle_x = 8'd150;
    next_move("paddle_in_period", 6);
    check("paddle_in_y_du", y_du, 0);
    check("paddle_in_x_du", x_du, 1);

    // Top wall bounce restores y_du
    x = 8'd80; y = 7'd0;
    next_move("top_period", 6);
    check("top_y_du", y_du, 1);

    // Paddle miss
    x = 8'd149; y = 7'd115;
    next_move("paddle_out_period", 6);
    check("paddle_out_y_du", y_du, 1);

    // Paddle hit again to get y_du=0
    x = 8'd155;
    next_move("paddle2_period", 6);
    check("paddle2_y_du", y_du, 0);

    // Top wall plus brick in RUN: single toggle
    x = 8'd80; y = 7'd0;
    tick();
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    next_move("brick_run_latency", 4);
    check("brick_single_toggle", y_du, 1);

    // Brick coincident with CHECK is deferred
    y = 7'd50;
    repeat (5) tick();
    check("pre_check_enable", enable, 0);
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    check("coinc_move_enable", enable, 1);
    check("coinc_not_folded", y_du, 1);
    next_move("coinc_period", 6);
    check("coinc_deferred", y_du, 0);

    // start during RUN ignored; top wall and right wall together
    x = 8'd159; y = 7'd0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    next_move("start_in_run_period", 4);
    check("combo_y_du", y_du, 1);
    check("combo_x_du", x_du, 0);
    check("combo_running", running, 1);

    // Ball lost
    y = 7'd119;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lost_no_enable", enable, 0);
    end
    tick();
    check("lost_pulse", ball_lost, 1);
    check("lost_enable", enable, 0);
    check("lost_running", running, 1);
    tick();
    check("lost_pulse_end", ball_lost, 0);
    check("lost_idle", running, 0);
    check("lost_x_du", x_du, 1);
    check("lost_y_du", y_du, 1);

    // Brick in IDLE ignored
    x = 8'd80; y = 7'd50;
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    tick();
    check("idle_enable", enable, 0);
    check("idle_running", running, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    next_move("relaunch_latency", 5);
    check("idle_brick_ignored", y_du, 1);

    // Reset during MOVE
    reset = 1'b1;
    tick();
    check("rst_move_enable", enable, 0);
    check("rst_move_running", running, 0);
    reset = 1'b0;
    tick();
    check("rst_hold_idle", running, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    next_move("post_rst_latency", 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
